// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory and feeds decode, with bubbles after reset/redirect and a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        polling_hold,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID,
  output logic        err_IF
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_F;
  logic [31:0] skid_instr;
  logic        skid_valid;
  logic        stall;

  assign stall       = stall_IF | polling_hold;
  assign imem_addr   = pc_F;
  assign imem_req    = !rst;
  assign pc_plus4_ID = pc_ID + 32'd4;

  // The memory answers one cycle late, so a held instruction must come from
  // the skid buffer: imem_rdata already reflects pc_F during a stall.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    instr_ID = imem_rdata;
    if (skid_valid)
      instr_ID = skid_instr;
    else if (!valid_ID)
      instr_ID = NOP_INSTR;
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset branch
  // is asynchronous and covers every register, including the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_F       <= RESET_PC;
      pc_ID      <= RESET_PC;
      valid_ID   <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      err_IF     <= 1'b0;
    end else if (redirect_en) begin
      // Redirect wins over any hold; pc_ID is meaningless while valid_ID is low.
      state      <= BOOT;
      pc_F       <= {redirect_pc[31:2], 2'b00};
      valid_ID   <= 1'b0;
      skid_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00)
        err_IF <= 1'b1;
    end else if (stall) begin
      if (state != STALL) begin
        skid_instr <= instr_ID;
        skid_valid <= valid_ID;
        state      <= STALL;
      end
    end else begin
      state      <= RUN;
      pc_ID      <= pc_F;
      pc_F       <= pc_F + 32'd4;
      valid_ID   <= 1'b1;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic checked against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IF, polling_hold, redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req;
  logic [31:0] instr_ID, pc_ID, pc_plus4_ID;
  logic        valid_ID, err_IF;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the address being fetched, the PC handed to decode, and whether
  // decode holds a real instruction. A valid slot always carries mem[pc].
  logic [31:0] m_pc_f, m_pc_id;
  logic        m_valid, m_err;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .polling_hold(polling_hold),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .instr_ID(instr_ID), .pc_ID(pc_ID), .pc_plus4_ID(pc_plus4_ID),
    .valid_ID(valid_ID), .err_IF(err_IF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_f = 32'h0050_0093;
      32'h0000_0004: mem_f = 32'h0010_0113;
      default:       mem_f = ((a ^ 32'h5A5A_A5A5) * 32'h9E37_79B1) | 32'h0000_0100;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= mem_f(imem_addr);

  task automatic model_reset();
    m_pc_f = 32'h0; m_pc_id = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (redirect_en) begin
      m_pc_f  = {redirect_pc[31:2], 2'b00};
      m_valid = 1'b0;
      if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
    end else if (!(stall_IF || polling_hold)) begin
      m_pc_id = m_pc_f;
      m_pc_f  = m_pc_f + 32'd4;
      m_valid = 1'b1;
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic r, input logic [31:0] t);
    stall_IF = s; polling_hold = p; redirect_en = r; redirect_pc = t;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    #1;
    model_reset();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (valid_ID !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_ID); else n_pass++;
    n_checks++; if (instr_ID !== NOP) $display("FAIL reset_instr: got %h want %h", instr_ID, NOP); else n_pass++;
    n_checks++; if (pc_ID !== 32'h0) $display("FAIL reset_pc_id: got %h want 0", pc_ID); else n_pass++;
    n_checks++; if (pc_plus4_ID !== 32'h4) $display("FAIL reset_pc4: got %h want 4", pc_plus4_ID); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
    n_checks++; if (err_IF !== 1'b0) $display("FAIL reset_err: got %b want 0", err_IF); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (valid_ID !== 1'b0 || instr_ID !== NOP) $display("FAIL boot_bubble: got %b/%h want 0/%h", valid_ID, instr_ID, NOP); else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL boot_req: got %b want 1", imem_req); else n_pass++;
    tick();
    n_checks++; if (pc_ID !== 32'h0 || instr_ID !== 32'h0050_0093 || valid_ID !== 1'b1)
      $display("FAIL first_instr: got pc=%h instr=%h v=%b want pc=0 instr=00500093 v=1", pc_ID, instr_ID, valid_ID); else n_pass++;
    tick();
    n_checks++; if (pc_ID !== 32'h4 || pc_plus4_ID !== 32'h8 || instr_ID !== 32'h0010_0113)
      $display("FAIL second_instr: got pc=%h pc4=%h instr=%h want 4/8/00100113", pc_ID, pc_plus4_ID, instr_ID); else n_pass++;
  endtask

  task automatic test_stall();
    tick(); tick(); tick();
    n_checks++; if (pc_ID !== 32'h10) $display("FAIL stall_setup: got %h want 10", pc_ID); else n_pass++;
    drive(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_ID !== 32'h10 || instr_ID !== mem_f(32'h10) || valid_ID !== 1'b1)
        $display("FAIL stall_hold%0d: got pc=%h instr=%h v=%b want 10/%h/1", i, pc_ID, instr_ID, valid_ID, mem_f(32'h10)); else n_pass++;
      n_checks++; if (imem_addr !== 32'h14) $display("FAIL stall_addr%0d: got %h want 14", i, imem_addr); else n_pass++;
    end
    drive(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_ID !== 32'h14 || instr_ID !== mem_f(32'h14))
      $display("FAIL stall_release: got pc=%h instr=%h want 14/%h", pc_ID, instr_ID, mem_f(32'h14)); else n_pass++;
    tick();
    n_checks++; if (pc_ID !== 32'h18 || instr_ID !== mem_f(32'h18))
      $display("FAIL stall_after: got pc=%h instr=%h want 18/%h", pc_ID, instr_ID, mem_f(32'h18)); else n_pass++;
  endtask

  task automatic test_redirect();
    tick();
    n_checks++; if (imem_addr !== 32'h20) $display("FAIL redir_setup: got %h want 20", imem_addr); else n_pass++;
    drive(0, 0, 1, 32'h100);
    tick();
    n_checks++; if (imem_addr !== 32'h100 || valid_ID !== 1'b0 || instr_ID !== NOP)
      $display("FAIL redir_bubble: got addr=%h v=%b instr=%h want 100/0/%h", imem_addr, valid_ID, instr_ID, NOP); else n_pass++;
    drive(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_ID !== 32'h100 || valid_ID !== 1'b1 || instr_ID !== mem_f(32'h100))
      $display("FAIL redir_target: got pc=%h v=%b instr=%h want 100/1/%h", pc_ID, valid_ID, instr_ID, mem_f(32'h100)); else n_pass++;
  endtask

  task automatic test_redirect_over_polling();
    drive(0, 1, 1, 32'h102);
    tick();
    n_checks++; if (imem_addr !== 32'h100 || valid_ID !== 1'b0)
      $display("FAIL redir_poll: got addr=%h v=%b want 100/0", imem_addr, valid_ID); else n_pass++;
    n_checks++; if (err_IF !== 1'b1) $display("FAIL misalign_err: got %b want 1", err_IF); else n_pass++;
    drive(0, 1, 0, 32'h0);
    tick(); tick();
    n_checks++; if (imem_addr !== 32'h100 || valid_ID !== 1'b0 || instr_ID !== NOP)
      $display("FAIL boot_stall: got addr=%h v=%b instr=%h want 100/0/%h", imem_addr, valid_ID, instr_ID, NOP); else n_pass++;
    drive(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (pc_ID !== 32'h100 || valid_ID !== 1'b1 || instr_ID !== mem_f(32'h100) || err_IF !== 1'b1)
      $display("FAIL boot_release: got pc=%h v=%b instr=%h err=%b want 100/1/%h/1", pc_ID, valid_ID, instr_ID, err_IF, mem_f(32'h100)); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    tick(); tick();
    drive(1, 0, 0, 32'h0);
    tick(); tick();
    n_checks++; if (pc_ID !== 32'h108 || valid_ID !== 1'b1)
      $display("FAIL midstall_setup: got pc=%h v=%b want 108/1", pc_ID, valid_ID); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b0 || instr_ID !== NOP || imem_addr !== 32'h0)
      $display("FAIL async_reset: got pc=%h v=%b instr=%h addr=%h want 0/0/%h/0", pc_ID, valid_ID, instr_ID, imem_addr, NOP); else n_pass++;
    n_checks++; if (err_IF !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL async_reset_flags: got err=%b req=%b want 0/0", err_IF, imem_req); else n_pass++;
    drive(0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (valid_ID !== 1'b0 || instr_ID !== NOP) $display("FAIL restart_bubble: got %b/%h want 0/%h", valid_ID, instr_ID, NOP); else n_pass++;
    tick();
    n_checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b1 || instr_ID !== 32'h0050_0093)
      $display("FAIL restart_first: got pc=%h v=%b instr=%h want 0/1/00500093", pc_ID, valid_ID, instr_ID); else n_pass++;
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 32'hFFFF_FFF8);
    tick();
    drive(0, 0, 0, 32'h0);
    tick();
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want fffffffc", imem_addr); else n_pass++;
    tick();
    n_checks++; if (imem_addr !== 32'h0 || pc_ID !== 32'hFFFF_FFFC || pc_plus4_ID !== 32'h0)
      $display("FAIL wrap_pc: got addr=%h pc=%h pc4=%h want 0/fffffffc/0", imem_addr, pc_ID, pc_plus4_ID); else n_pass++;
    n_checks++; if (err_IF !== 1'b0) $display("FAIL wrap_err: got %b want 0", err_IF); else n_pass++;
    tick();
    n_checks++; if (pc_ID !== 32'h0 || instr_ID !== 32'h0050_0093)
      $display("FAIL wrap_next: got pc=%h instr=%h want 0/00500093", pc_ID, instr_ID); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [31:0] exp_instr;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
      end else begin
        t = $urandom;
        if ($urandom_range(4) != 0) t[1:0] = 2'b00;
        drive($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0, t);
        tick();
      end
      exp_instr = m_valid ? mem_f(m_pc_id) : NOP;
      n_checks++; if (imem_addr !== m_pc_f) $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc_f); else n_pass++;
      n_checks++; if (imem_req !== !rst) $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, !rst); else n_pass++;
      n_checks++; if (valid_ID !== m_valid) $display("FAIL rnd_valid@%0d: got %b want %b", i, valid_ID, m_valid); else n_pass++;
      n_checks++; if (instr_ID !== exp_instr) $display("FAIL rnd_instr@%0d: got %h want %h", i, instr_ID, exp_instr); else n_pass++;
      n_checks++; if (err_IF !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", i, err_IF, m_err); else n_pass++;
      if (m_valid) begin
        n_checks++; if (pc_ID !== m_pc_id || pc_plus4_ID !== m_pc_id + 32'd4)
          $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", i, pc_ID, pc_plus4_ID, m_pc_id, m_pc_id + 32'd4); else n_pass++;
      end
      if (rst) begin
        drive(0, 0, 0, 32'h0);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_over_polling();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It sits directly upstream of the decode stage. It owns the PC and drives a synchronous-read instruction memory. It presents the instruction, its PC and PC+4 to decode, inserting NOP bubbles after reset and redirects and holding stable output during stalls via a one-entry skid buffer. Decode's `polling` output feeds back here as a hold request.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; must be word-aligned.
- `NOP_INSTR`, default `32'h0000_0013` (addi x0,x0,0): bubble instruction.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_IF`  in  1  hazard-unit hold request.
- `polling_hold`  in  1  hold request from decode `polling`; ORed with `stall_IF` into `stall`.
- `redirect_en`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  32  redirect target.
- `imem_addr`  out  32  fetch address (= `pc_F`).
- `imem_req`  out  1  fetch request.
- `imem_rdata`  in  32  instruction for the address presented in the previous cycle.
- `instr_ID`  out  32  instruction to decode.
- `pc_ID`  out  32  PC of `instr_ID`.
- `pc_plus4_ID`  out  32  `pc_ID + 4`, mod 2^32.
- `valid_ID`  out  1  `instr_ID` is a real instruction, not a bubble.
- `err_IF`  out  1  sticky misaligned-redirect flag.

## Operation
- Registers: `pc_F`, `pc_ID`, `valid_ID`, `skid_instr`, `skid_valid`, `state`, `err_IF`.
- `imem_addr = pc_F`; `imem_req = !rst`.
- `instr_ID` mux:
  - `skid_valid` → `skid_instr`.
  - else `!valid_ID` → `NOP_INSTR`.
  - else → `imem_rdata`.
- States:
  - BOOT: entered on reset.
  - RUN.
  - STALL.
- Event priority per edge: `redirect_en` > `stall` > advance.
- Advance (no redirect, no stall):
  - `pc_ID <= pc_F`, `pc_F <= pc_F + 4`, `valid_ID <= 1`, `skid_valid <= 0`.
  - Next state is RUN.
- Stall entered from RUN or BOOT:
  - `skid_instr <= instr_ID` (current mux output); `skid_valid <= valid_ID`.
  - `pc_F`, `pc_ID` and `valid_ID` hold; next state is STALL.
- Stall while in STALL: everything holds.
- Redirect, in any state and regardless of stall:
  - `pc_F <= {redirect_pc[31:2], 2'b00}`, `valid_ID <= 0`, `skid_valid <= 0`.
  - Next state is BOOT; `pc_ID` is don't-care but holds.
- Misaligned redirect: if `redirect_en && redirect_pc[1:0] != 0`, then `err_IF <= 1`. `err_IF` is cleared only by `rst`.
- PC wrap: `32'hFFFF_FFFC + 4 = 0`; no error is raised.
- BOOT behaves as RUN with `valid_ID = 0`. Its only purpose is to cover the one-cycle memory latency for the first fetch after reset or redirect.

## Timing
- Reset values:
  - `pc_F = RESET_PC`, `pc_ID = RESET_PC`, `pc_plus4_ID = RESET_PC + 4`.
  - `valid_ID = 0`, `instr_ID = NOP_INSTR`.
  - `skid_valid = 0`, `err_IF = 0`, `imem_req = 0`, state BOOT.
- Fetch latency:
  - Address A is presented in cycle N.
  - A reaches `pc_ID` at the edge ending N.
  - `instr_ID = mem[A]` during N+1.
- After reset release: the first valid instruction (`RESET_PC`) appears one cycle after the first edge.
- Redirect penalty: exactly one bubble cycle (`valid_ID = 0`). The target instruction is valid two cycles after the redirect edge.
- Stall of K cycles: `instr_ID`, `pc_ID` and `valid_ID` stay constant for K+1 cycles, starting from the cycle in which `stall` is first high.
- Memory addressing during stall:
  - `imem_addr` stays at `pc_F` throughout.
  - The instruction at `pc_F` is therefore available on `imem_rdata` on the cycle after release.
  - No refetch cycle is needed.
- Reset asserted mid-stall or mid-redirect:
  - All state returns to reset values immediately (asynchronous).
  - The skid contents are discarded.
- Redirect and stall in the same cycle: the redirect is taken and the stall is ignored for that edge.

## Test plan
- Reset with memory holding `mem[0]=0x00500093`, `mem[4]=0x00100113`, then release:
  - Cycle 1: `valid_ID=0`, `instr_ID=0x00000013`.
  - Cycle 2: `pc_ID=0`, `instr_ID=0x00500093`.
  - Cycle 3: `pc_ID=4`, `pc_plus4_ID=8`.
- `stall_IF` high for 3 cycles while `pc_ID=0x10`:
  - `instr_ID` and `pc_ID=0x10` stay constant for 4 cycles.
  - `imem_addr` stays at `0x14`.
  - On the following cycle `pc_ID=0x14` with `mem[0x14]`; no instruction is lost or duplicated.
- `redirect_en=1` with `redirect_pc=0x100` while `pc_F=0x20`:
  - Next cycle: `imem_addr=0x100`, `valid_ID=0`.
  - The cycle after: `pc_ID=0x100`, `instr_ID=mem[0x100]`, `valid_ID=1`.
- `redirect_en` asserted together with `polling_hold`, target `0x102`:
  - Redirect wins; `imem_addr=0x100`.
  - `err_IF` goes to 1 and stays 1 until `rst`.
- `pc_F=0xFFFFFFFC` with no stall: next `imem_addr=0x00000000` and `err_IF` remains 0.
- `rst` pulsed during a stall with `skid_valid=1`:
  - Outputs return immediately to reset values.
  - After release, fetch restarts at `RESET_PC` with one bubble.
